// File: rtl/bist_pkg.sv
// Shared constants and state encoding for the BIST sequencing logic.
package bist_pkg;

  // Pulse-controller loop limits; one nominal session is (N_MAX+1)*(M_MAX+1) = 9747 cycles.
  localparam int N_MAX       = 18;
  localparam int M_MAX       = 512;
  localparam int TIMEOUT_DEF = 16384;
  localparam int TO_W_DEF    = 15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_GAP    = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } sched_state_t;

endpackage

// File: rtl/counter_15b.sv
// Free-running up-counter with synchronous clear and count enable (watchdog timer).
module counter_15b #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/bist_scheduler.sv
// Runs one BIST controller session per enabled CUT, lowest index first, with a per-session watchdog.
module bist_scheduler
  import bist_pkg::*;
#(
  parameter int N_CUT   = 4,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [N_CUT-1:0] cut_mask,
  output logic             ctrl_start,
  input  logic             ctrl_running,
  input  logic             ctrl_bist_end,
  input  logic             sig_ok,
  output logic [SEL_W-1:0] cut_sel,
  output logic             busy,
  output logic             done,
  output logic [N_CUT-1:0] pass_vec,
  output logic             timeout_err
);

  sched_state_t     state_reg, state_next;
  logic             go_q;
  logic             armed_reg;
  logic [N_CUT-1:0] mask_reg, mask_next;
  logic [N_CUT-1:0] pass_next;
  logic [SEL_W-1:0] sel_next, lsb_idx;
  logic             gap_reg, gap_next;
  logic [TO_W-1:0]  wd_count;
  logic             wd_active, wd_expired, go_edge;

  // armed_reg masks a go edge that lands on the first clock after reset release
  assign go_edge    = go & ~go_q & armed_reg;
  assign wd_active  = (state_reg == S_START) || (state_reg == S_RUN);
  assign wd_expired = wd_active && (wd_count == TO_W'(TIMEOUT - 1));

  counter_15b #(.W(TO_W)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (~wd_active),
    .en      (wd_active),
    .count   (wd_count)
  );

  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    pass_next  = pass_vec;
    gap_next   = gap_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        if (go_edge) begin
          mask_next  = cut_mask;
          pass_next  = '0;
          state_next = S_SELECT;
        end
      end
      S_SELECT: begin
        if (mask_reg == '0) begin
          state_next = S_DONE;
        end else begin
          for (int i = 0; i < N_CUT; i++)
            if (SEL_W'(i) == cut_sel) mask_next[i] = 1'b0;
          state_next = S_START;
        end
      end
      S_START: begin
        if (wd_expired)
          state_next = S_ERROR;
        else if (ctrl_running)
          state_next = S_RUN;
      end
      S_RUN: begin
        // a finishing session takes priority over a watchdog expiry in the same cycle
        if (ctrl_bist_end && !ctrl_running) begin
          for (int i = 0; i < N_CUT; i++)
            if (SEL_W'(i) == cut_sel) pass_next[i] = sig_ok;
          gap_next   = 1'b0;
          state_next = S_GAP;
        end else if (wd_expired) begin
          state_next = S_ERROR;
        end
      end
      S_GAP: begin
        if (gap_reg)
          state_next = S_SELECT;
        else
          gap_next = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // cut_sel is loaded on entry to SELECT so it is stable a full cycle before ctrl_start rises
  always_comb begin
    lsb_idx = '0;
    for (int i = N_CUT - 1; i >= 0; i--)
      if (mask_next[i]) lsb_idx = SEL_W'(i);
    sel_next = ((state_next == S_SELECT) && (mask_next != '0)) ? lsb_idx : cut_sel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      go_q        <= 1'b0;
      armed_reg   <= 1'b0;
      mask_reg    <= '0;
      pass_vec    <= '0;
      cut_sel     <= '0;
      gap_reg     <= 1'b0;
      ctrl_start  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_reg   <= state_next;
      go_q        <= go;
      armed_reg   <= 1'b1;
      mask_reg    <= mask_next;
      pass_vec    <= pass_next;
      cut_sel     <= sel_next;
      gap_reg     <= gap_next;
      ctrl_start  <= (state_next == S_START);
      busy        <= state_next inside {S_SELECT, S_START, S_RUN, S_GAP};
      done        <= (state_next == S_DONE) || (state_next == S_ERROR);
      timeout_err <= (state_next == S_ERROR);
    end
  end

endmodule

// File: tb/tb_bist_scheduler.sv
// Scheduler bench: behavioural controller stub, table of directed sequences, random sequences vs. a reference model.
module tb_bist_scheduler;

  localparam int N_CUT   = 4;
  localparam int SEL_W   = 2;
  localparam int TIMEOUT = 64;
  localparam int TO_W    = 7;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             go = 1'b0;
  logic [N_CUT-1:0] cut_mask = '0;
  logic             ctrl_start, ctrl_running, ctrl_bist_end, sig_ok;
  logic [SEL_W-1:0] cut_sel;
  logic             busy, done, timeout_err;
  logic [N_CUT-1:0] pass_vec;

  logic [N_CUT-1:0] sig_vec = '0;
  int               hang_cut = -1;

  int checks = 0;
  int failures = 0;

  bist_scheduler #(.N_CUT(N_CUT), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .go            (go),
    .cut_mask      (cut_mask),
    .ctrl_start    (ctrl_start),
    .ctrl_running  (ctrl_running),
    .ctrl_bist_end (ctrl_bist_end),
    .sig_ok        (sig_ok),
    .cut_sel       (cut_sel),
    .busy          (busy),
    .done          (done),
    .pass_vec      (pass_vec),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  assign sig_ok = sig_vec[cut_sel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Controller stub: running rises two cycles after a start edge, lasts a random time, then
  // bist_end is raised and held (stale) until the next session's running rises.
  logic       st_q, pend;
  logic [3:0] run_cnt;
  logic       hang_now;
  assign hang_now = (hang_cut == int'(cut_sel));

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= 1'b0; pend <= 1'b0; ctrl_running <= 1'b0; ctrl_bist_end <= 1'b0; run_cnt <= '0;
    end else begin
      st_q <= ctrl_start;
      if (ctrl_start && !st_q) begin
        pend <= 1'b1;
        ctrl_running <= 1'b0;
      end else if (pend) begin
        pend <= 1'b0;
        ctrl_running <= 1'b1;
        ctrl_bist_end <= 1'b0;
        run_cnt <= 4'($urandom_range(0, 12));
      end else if (ctrl_running && !hang_now) begin
        if (run_cnt == 0) begin
          ctrl_running <= 1'b0;
          ctrl_bist_end <= 1'b1;
        end else begin
          run_cnt <= run_cnt - 1'b1;
        end
      end
    end
  end

  // Monitor: records which CUT each start pulse addressed and when the watchdog fired.
  int         cyc = 0, n_starts = 0, last_start_cyc = 0, terr_cyc = 0;
  int         obs_order[$];
  logic       start_prev = 1'b0, terr_prev = 1'b0;
  logic [SEL_W-1:0] sel_prev = '0;

  always @(negedge clk) begin
    cyc++;
    if (ctrl_start && !start_prev) begin
      obs_order.push_back(int'(cut_sel));
      n_starts++;
      last_start_cyc = cyc;
      check("sel_stable_before_start", 32'(cut_sel), 32'(sel_prev));
    end
    if (timeout_err && !terr_prev) terr_cyc = cyc;
    start_prev = ctrl_start;
    terr_prev  = timeout_err;
    sel_prev   = cut_sel;
  end

  task automatic run_seq(input string name, input logic [N_CUT-1:0] mask, input logic [N_CUT-1:0] sig,
                         input int hang, input logic [N_CUT-1:0] exp_pass, input logic exp_terr,
                         input int exp_starts, input bit go_games);
    int t;
    int base;
    bit ok;
    int exp_order[$];
    cut_mask = mask; sig_vec = sig; hang_cut = hang;
    obs_order.delete();
    base = n_starts;
    for (int i = 0; i < N_CUT; i++) begin
      if (mask[i]) begin
        exp_order.push_back(i);
        if (i == hang) break;
      end
    end
    @(negedge clk) go = 1'b0;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    cut_mask = ~mask;
    check({name, "_done_cleared"}, 32'(done), 32'd0);
    check({name, "_terr_cleared"}, 32'(timeout_err), 32'd0);
    check({name, "_busy_after_go"}, 32'(busy), 32'd1);
    t = 0;
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
      if (go_games) begin
        if (t == 3) go = 1'b1;
        if (t == 4) go = 1'b0;
        if (t == 6) go = 1'b1;
      end
    end
    check({name, "_done_in_time"}, 32'(t < 2000), 32'd1);
    if (mask == '0) check({name, "_done_latency_le2"}, 32'(t <= 2), 32'd1);
    @(negedge clk);
    check({name, "_pass_vec"}, 32'(pass_vec), 32'(exp_pass));
    check({name, "_timeout_err"}, 32'(timeout_err), 32'(exp_terr));
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_done_end"}, 32'(done), 32'd1);
    check({name, "_start_low"}, 32'(ctrl_start), 32'd0);
    check({name, "_n_starts"}, 32'(n_starts - base), 32'(exp_starts));
    ok = (obs_order.size() == exp_order.size());
    for (int i = 0; i < exp_order.size(); i++)
      if (ok && obs_order[i] != exp_order[i]) ok = 1'b0;
    check({name, "_cut_order"}, 32'(ok), 32'd1);
    if (exp_terr) check({name, "_watchdog_cycles"}, 32'(terr_cyc - last_start_cyc), 32'(TIMEOUT));
    $display("seq %s mask=%b sig=%b hang=%0d pass_vec=%b timeout_err=%0d starts=%0d",
             name, mask, sig, hang, pass_vec, timeout_err, n_starts - base);
  endtask

  typedef struct {
    string            name;
    logic [N_CUT-1:0] mask;
    logic [N_CUT-1:0] sig;
    int               hang;
    logic [N_CUT-1:0] exp_pass;
    logic             exp_terr;
    int               exp_starts;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [N_CUT-1:0] m, s, ep;
    logic             et;
    int               h, n, t, base;

    vecs[0] = '{"all_pass",  4'b1111, 4'b1111, -1, 4'b1111, 1'b0, 4};
    vecs[1] = '{"cut3_fail", 4'b1010, 4'b0111, -1, 4'b0010, 1'b0, 2};
    vecs[2] = '{"empty",     4'b0000, 4'b1111, -1, 4'b0000, 1'b0, 0};
    vecs[3] = '{"hang_cut1", 4'b0110, 4'b1111,  1, 4'b0000, 1'b1, 1};
    vecs[4] = '{"hang_cut2", 4'b1101, 4'b1111,  2, 4'b0001, 1'b1, 2};
    vecs[5] = '{"mixed",     4'b1011, 4'b1001, -1, 4'b1001, 1'b0, 3};

    repeat (3) @(negedge clk);
    check("reset_outputs_zero", 32'({ctrl_start, busy, done, pass_vec, timeout_err, cut_sel}), 32'd0);
    reset_n = 1'b1;

    for (int v = 0; v < 6; v++)
      run_seq(vecs[v].name, vecs[v].mask, vecs[v].sig, vecs[v].hang,
              vecs[v].exp_pass, vecs[v].exp_terr, vecs[v].exp_starts, 1'b0);

    // go toggled and then held high while busy; the held level must not restart from DONE
    run_seq("go_while_busy", 4'b1111, 4'b1111, -1, 4'b1111, 1'b0, 4, 1'b1);
    base = n_starts;
    repeat (8) @(negedge clk);
    check("go_held_no_restart_busy", 32'(busy), 32'd0);
    check("go_held_no_restart_starts", 32'(n_starts - base), 32'd0);
    go = 1'b0;
    @(negedge clk) go = 1'b1;
    @(negedge clk);
    check("go_reedge_restarts", 32'(busy), 32'd1);
    go = 1'b0;
    t = 0;
    while (!done && t < 2000) begin @(negedge clk); t++; end
    check("go_reedge_done", 32'(t < 2000), 32'd1);

    // asynchronous reset in the middle of the second session
    cut_mask = 4'b1111; sig_vec = 4'b1111; hang_cut = -1;
    base = n_starts;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    t = 0;
    while (n_starts - base < 2 && t < 500) begin @(negedge clk); t++; end
    check("reached_session2", 32'(t < 500), 32'd1);
    #1 reset_n = 1'b0;
    go = 1'b1;
    #1 check("async_reset_outputs_zero",
             32'({ctrl_start, busy, done, pass_vec, timeout_err, cut_sel}), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("release_with_go_high_idle", 32'({busy, done, ctrl_start}), 32'd0);
    go = 1'b0;

    for (int r = 0; r < 20; r++) begin
      m = 4'($urandom_range(0, 15));
      s = 4'($urandom_range(0, 15));
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      ep = '0; et = 1'b0; n = 0;
      for (int i = 0; i < N_CUT; i++) begin
        if (m[i]) begin
          n++;
          if (i == h) begin
            et = 1'b1;
            break;
          end
          if (s[i]) ep[i] = 1'b1;
        end
      end
      run_seq($sformatf("rand%0d", r), m, s, h, ep, et, n, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
